// File: rtl/mux_sync_tx_if.sv
`default_nettype none
// ============================================================================
// Module : mux_sync_tx_if
// Brief  : Stream-in / synchronizer-out signal bundle for mux_sync_tx.
// Rev    : 1.0  initial release
// ============================================================================
interface mux_sync_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_en;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  data_out,
    input  data_en
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output data_out,
    output data_en
  );
endinterface
`default_nettype wire

// File: rtl/mux_sync_tx.sv
`default_nettype none
// ============================================================================
// Module : mux_sync_tx
// Brief  : Source-domain transmitter feeding a mux-based CDC synchronizer.
// Rev    : 1.0  initial release
// ============================================================================
module mux_sync_tx #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 8
) (
  input  wire logic               clk_a,
  input  wire logic               arstn,
  mux_sync_tx_if.slave            bus,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int MAXHG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW    = $clog2(MAXHG) + 1;

  localparam logic [CW-1:0] c_hold_load = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] c_gap_load  = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   c_full      = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HOLD  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_data_en, w_data_en_nxt;
  logic [WIDTH-1:0] r_data_out;
  logic             w_pop, w_push;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;

  // Ready masked by reset so nothing upstream sees a false accept while held.
  assign bus.in_ready = arstn && (r_count < c_full);
  assign w_push       = bus.in_valid && bus.in_ready;
  assign bus.data_out = r_data_out;
  assign bus.data_en  = r_data_en;
  assign fifo_count   = r_count;
  assign busy         = (r_state != S_IDLE) || (r_count != '0);

  always_ff @(posedge clk_a) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_data_en  <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data_en <= w_data_en_nxt;
      if (w_pop) r_data_out <= r_mem[r_rd_ptr];
    end
  end

  // data_out is loaded only on a pop, so it stays frozen through SETUP/HOLD/GAP.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_data_en_nxt = r_data_en;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_data_en_nxt = 1'b0;
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_data_en_nxt = 1'b1;
        w_cnt_nxt     = c_hold_load;
        w_state_nxt   = S_HOLD;
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_data_en_nxt = 1'b0;
          w_cnt_nxt     = c_gap_load;
          w_state_nxt   = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_data_en_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_sync_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_mux_sync_tx
// Brief  : Randomized bench for mux_sync_tx against a queue/timeline model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mux_sync_tx;
  localparam int WIDTH  = 4;
  localparam int DEPTH  = 4;
  localparam int HOLD   = 8;
  localparam int GAP    = 8;
  localparam int PERIOD = HOLD + GAP + 2;

  logic                   clk_a = 1'b0;
  logic                   clk_b = 1'b0;
  logic                   arstn;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;

  mux_sync_tx_if #(.WIDTH(WIDTH)) bus ();

  mux_sync_tx #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
  ) dut (
    .clk_a(clk_a), .arstn(arstn), .bus(bus), .busy(busy), .fifo_count(fifo_count)
  );

  always #5  clk_a = ~clk_a;
  always #10 clk_b = ~clk_b;

  int n_total = 0;
  int n_bad   = 0;

  // Reference: word queue plus a timeline of when each word leaves the FIFO.
  int m_q[$];
  int m_word;
  int m_last_pop;
  int m_next_free;
  bit m_pushed;
  int cyc = 0;

  int out_log[$];
  int rx_q[$];
  bit prev_en = 1'b0;
  int prev_rise = -1;
  bit spacing_on = 1'b0;

  logic [2:0] en_s = 3'b000;

  // Simple receiver in clk_b: two-flop enable sync, latch data on sync'd rise.
  always @(posedge clk_b) begin
    en_s <= {en_s[1:0], bus.data_en};
    if (en_s[1] && !en_s[2]) rx_q.push_back(int'(bus.data_out));
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_word      = 0;
    m_last_pop  = -1000;
    m_next_free = 0;
  endtask

  task automatic tick();
    bit do_pop, do_push;
    int exp_en, exp_busy, exp_ready;
    do_pop  = arstn && (m_q.size() > 0) && (cyc >= m_next_free);
    do_push = arstn && bus.in_valid && (m_q.size() < DEPTH);
    @(posedge clk_a);
    if (do_pop) begin
      m_word      = m_q.pop_front();
      m_last_pop  = cyc;
      m_next_free = cyc + PERIOD;
    end
    if (do_push) m_q.push_back(int'(bus.in_data));
    m_pushed = do_push;
    #1;
    exp_en    = (cyc >= m_last_pop + 1) && (cyc <= m_last_pop + HOLD);
    exp_busy  = (cyc <= m_last_pop + PERIOD - 2) || (m_q.size() != 0);
    exp_ready = arstn && (m_q.size() < DEPTH);
    check_val("count", 32'(fifo_count), 32'(m_q.size()));
    check_val("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check_val("data_out", 32'(bus.data_out), 32'(m_word));
    check_val("data_en", 32'(bus.data_en), 32'(exp_en));
    check_val("busy", 32'(busy), 32'(exp_busy));
    if (bus.data_en && !prev_en) begin
      out_log.push_back(int'(bus.data_out));
      if (spacing_on && prev_rise >= 0) check_val("rise_gap", 32'(cyc - prev_rise), 32'(PERIOD));
      prev_rise = cyc;
    end
    prev_en = bus.data_en;
    cyc++;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_word(input int val);
    int w;
    bus.in_data  = WIDTH'(val);
    bus.in_valid = 1'b1;
    w = 0;
    tick();
    while (!m_pushed && w < 40) begin
      tick();
      w++;
    end
    if (!m_pushed) check_val("push_timeout", 32'(0), 32'(1));
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int w;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    arstn        = 1'b0;
    model_reset();
    #2;
    check_val("rst_en", 32'(bus.data_en), 32'(0));
    check_val("rst_data", 32'(bus.data_out), 32'(0));
    check_val("rst_ready", 32'(bus.in_ready), 32'(0));
    check_val("rst_count", 32'(fifo_count), 32'(0));
    check_val("rst_busy", 32'(busy), 32'(0));
    tick();
    tick();
    #2;
    arstn = 1'b1;
    #1;
    check_val("ready_release", 32'(bus.in_ready), 32'(1));
    idle(2);

    // Single word
    out_log.delete();
    push_word(4);
    idle(PERIOD + 2);
    check_val("single_n", 32'(out_log.size()), 32'(1));
    if (out_log.size() > 0) check_val("single_w", 32'(out_log[0]), 32'(4));

    // Burst 1..6 with in_valid held; back-to-back pulses
    out_log.delete();
    prev_rise  = -1;
    spacing_on = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      bus.in_data  = WIDTH'(k);
      bus.in_valid = 1'b1;
      w = 0;
      tick();
      while (!m_pushed && w < 40) begin
        tick();
        w++;
      end
      if (!m_pushed) check_val("burst_timeout", 32'(0), 32'(1));
    end
    idle(6 * PERIOD + 4);
    spacing_on = 1'b0;
    check_val("burst_n", 32'(out_log.size()), 32'(6));
    for (int k = 0; k < 6 && k < out_log.size(); k++) check_val("burst_w", 32'(out_log[k]), 32'(k + 1));

    // Stall on full FIFO: A presented but dropped before a slot frees
    out_log.delete();
    for (int k = 1; k <= 5; k++) push_word(k);
    bus.in_data  = 4'hA;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("stall_count", 32'(fifo_count), 32'(DEPTH));
    end
    idle(5 * PERIOD + 4);
    check_val("stall_n", 32'(out_log.size()), 32'(5));
    for (int k = 0; k < 5 && k < out_log.size(); k++) check_val("stall_w", 32'(out_log[k]), 32'(k + 1));

    // Reset in the middle of HOLD
    push_word(9);
    w = 0;
    while (!bus.data_en && w < 30) begin
      tick();
      w++;
    end
    if (!bus.data_en) check_val("hold_timeout", 32'(0), 32'(1));
    idle(3);
    arstn = 1'b0;
    model_reset();
    #1;
    check_val("midrst_en", 32'(bus.data_en), 32'(0));
    check_val("midrst_count", 32'(fifo_count), 32'(0));
    idle(2);
    #2;
    arstn = 1'b1;
    out_log.delete();
    idle(40);
    check_val("midrst_quiet", 32'(out_log.size()), 32'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 3) == 0);
      bus.in_data  = WIDTH'($urandom);
      tick();
    end
    idle(DEPTH * PERIOD + 10);

    // End-to-end through the clk_b receiver
    rx_q.delete();
    push_word(4);
    push_word(7);
    push_word(9);
    idle(3 * PERIOD + 20);
    check_val("e2e_n", 32'(rx_q.size()), 32'(3));
    if (rx_q.size() > 0) check_val("e2e_0", 32'(rx_q[0]), 32'(4));
    if (rx_q.size() > 1) check_val("e2e_1", 32'(rx_q[1]), 32'(7));
    if (rx_q.size() > 2) check_val("e2e_2", 32'(rx_q[2]), 32'(9));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
